// File: rtl/duc_core.sv
// Digital up-converter: rotates baseband I/Q by an NCO tone (e^{+j*phi}), then rounds
// and saturates to 16-bit DAC words. Fixed 6-cycle latency, one sample per clock.
module duc_core #(
    parameter string LUT_FILE = "cos_lut.mem"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] phase_in,
    input  logic        phase_valid,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        valid_out,
    output logic [31:0] dac_out
);

    typedef enum logic {
        UNCONF,
        RUN
    } state_t;

    // Cosine table is generated at elaboration with the same contents as the LUT_FILE image.
    localparam string unused_lut_file = LUT_FILE;

    localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

    function automatic logic signed [15:0] cos_entry(input int unsigned k);
        int unsigned         kk;
        logic                neg;
        logic signed [127:0] x;
        logic signed [127:0] term;
        logic signed [127:0] sum;
        logic signed [127:0] val;
        kk = k % 4096;
        if (kk > 2048) kk = 4096 - kk;
        neg = 1'b0;
        if (kk > 1024) begin
            kk  = 2048 - kk;
            neg = 1'b1;
        end
        x    = (PI_Q60 * $signed(128'(kk))) >>> 11;
        term = 128'sd1 <<< 60;
        sum  = term;
        for (int unsigned n = 1; n <= 14; n++) begin
            term = (term * x) >>> 60;
            term = (term * x) >>> 60;
            term = -term / $signed(128'(2 * n * (2 * n - 1)));
            sum  = sum + term;
        end
        val = (sum * 128'sd32767 + (128'sd1 <<< 59)) >>> 60;
        return neg ? 16'(-val) : 16'(val);
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767) return 16'sh7FFF;
        else if (v < -33'sd32768) return 16'sh8000;
        else return 16'(v);
    endfunction

    logic signed [15:0] rom [4096];

    for (genvar k = 0; k < 4096; k++) begin : g_rom
        localparam logic signed [15:0] ENTRY = cos_entry(k);
        assign rom[k] = ENTRY;
    end

    logic unused_phase;
    assign unused_phase = ^{phase_in[47:44], phase_in[23:20]};

    state_t state_q;
    state_t state_d;
    logic   accept;
    logic   flush;

    logic [19:0] acc_q;
    logic [19:0] pinc_q;
    logic [19:0] poff_q;
    logic [11:0] addr_d;

    always_comb begin
        state_d = state_q;
        if (phase_valid) state_d = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= UNCONF;
        else     state_q <= state_d;
    end

    // Config strobe wins over a coincident sample and flushes everything in flight.
    assign accept = (state_q == RUN) && valid_in && !phase_valid;
    assign flush  = rst || phase_valid;
    assign addr_d = 12'((acc_q + poff_q) >> 8);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            pinc_q <= '0;
            poff_q <= '0;
        end else if (phase_valid) begin
            pinc_q <= phase_in[19:0];
            poff_q <= phase_in[43:24];
            acc_q  <= '0;
        end else if (accept) begin
            acc_q <= acc_q + pinc_q;
        end
    end

    logic [6:1] vld;

    always_ff @(posedge clk) begin
        if (flush) vld <= '0;
        else       vld <= {vld[5:1], accept};
    end

    logic        [11:0] addr_q;
    logic signed [15:0] i1_q, q1_q, i2_q, q2_q, i3_q, q3_q;
    logic signed [15:0] cos_rd_q, sin_rd_q, cos_q, sin_q;
    logic signed [31:0] p_ic_q, p_qs_q, p_is_q, p_qc_q;
    logic signed [32:0] sum_i_q, sum_q_q;
    logic signed [32:0] rnd_i, rnd_q;
    logic signed [15:0] out_i_q, out_q_q;

    assign rnd_i = (sum_i_q + 33'sd16384) >>> 15;
    assign rnd_q = (sum_q_q + 33'sd16384) >>> 15;

    always_ff @(posedge clk) begin
        addr_q   <= addr_d;
        i1_q     <= data_in[15:0];
        q1_q     <= data_in[31:16];

        cos_rd_q <= rom[addr_q];
        sin_rd_q <= rom[addr_q + 12'd3072];
        i2_q     <= i1_q;
        q2_q     <= q1_q;

        cos_q    <= cos_rd_q;
        sin_q    <= sin_rd_q;
        i3_q     <= i2_q;
        q3_q     <= q2_q;

        p_ic_q   <= 32'(i3_q) * 32'(cos_q);
        p_qs_q   <= 32'(q3_q) * 32'(sin_q);
        p_is_q   <= 32'(i3_q) * 32'(sin_q);
        p_qc_q   <= 32'(q3_q) * 32'(cos_q);

        sum_i_q  <= 33'(p_ic_q) - 33'(p_qs_q);
        sum_q_q  <= 33'(p_is_q) + 33'(p_qc_q);

        out_i_q  <= sat16(rnd_i);
        out_q_q  <= sat16(rnd_q);
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            valid_out <= 1'b0;
            dac_out   <= '0;
        end else begin
            valid_out <= vld[6];
            dac_out   <= vld[6] ? {out_q_q, out_i_q} : '0;
        end
    end

endmodule

// File: tb/tb_duc_core.sv
// Scoreboard bench for duc_core: directed vectors push hand-computed outputs with their
// due edge; a negedge monitor pops and compares whenever valid_out is high.
module tb_duc_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] phase_in;
    logic        phase_valid;
    logic [31:0] data_in;
    logic        valid_in;
    logic        valid_out;
    logic [31:0] dac_out;

    always #5 clk = ~clk;

    duc_core #(.LUT_FILE("cos_lut.mem")) dut (
        .clk         (clk),
        .rst         (rst),
        .phase_in    (phase_in),
        .phase_valid (phase_valid),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .valid_out   (valid_out),
        .dac_out     (dac_out)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int unsigned edge_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    // {Q, I} words for I=1000, Q=0 rotated by 0, 90, 180, 270 degrees
    localparam logic [31:0] DC   = 32'h0000_03E8;
    localparam logic [31:0] P90  = 32'h03E8_0000;
    localparam logic [31:0] P180 = 32'h0000_FC18;
    localparam logic [31:0] P270 = 32'hFC18_0000;

    logic [31:0] quarter [4];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due < edge_cnt) begin
            checks++;
            errors++;
            $display("FAIL missing_out: no valid_out at edge %0d, required %h", sb[0].due, sb[0].data);
            void'(sb.pop_front());
        end
        checks++;
        if (valid_out) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: edge %0d got %h, required no output", edge_cnt, dac_out);
            end else begin
                e = sb.pop_front();
                if (e.due != edge_cnt || dac_out !== e.data) begin
                    errors++;
                    $display("FAIL out_data: edge %0d got %h, required %h at edge %0d",
                             edge_cnt, dac_out, e.data, e.due);
                end
            end
        end else if (dac_out !== 32'h0) begin
            errors++;
            $display("FAIL idle_zero: edge %0d dac_out %h while valid_out low, required 0", edge_cnt, dac_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic purge(input int unsigned from);
        while (sb.size() > 0 && sb[$].due >= from) void'(sb.pop_back());
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [15:0] i, input logic [15:0] q,
                        input logic [31:0] exp_v, input bit expect_out);
        exp_t e;
        valid_in = 1'b1;
        data_in  = {q, i};
        if (expect_out) begin
            e.due  = edge_cnt + 7;
            e.data = exp_v;
            sb.push_back(e);
        end
        tick();
    endtask

    // Ignored phase_in bits carry junk on purpose.
    task automatic configure(input logic [19:0] pinc, input logic [19:0] poff, input bit with_sample);
        phase_in    = {4'hF, poff, 4'hA, pinc};
        phase_valid = 1'b1;
        valid_in    = with_sample;
        data_in     = {16'd0, 16'd5000};
        purge(edge_cnt + 1);
        tick();
        phase_valid = 1'b0;
        valid_in    = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if (valid_out !== 1'b0 || dac_out !== 32'h0) begin
            errors++;
            $display("FAIL %s: valid_out %b dac_out %h, required 0 and 00000000", name, valid_out, dac_out);
        end
    endtask

    initial begin
        quarter[0] = DC;
        quarter[1] = P90;
        quarter[2] = P180;
        quarter[3] = P270;

        rst         = 1'b1;
        phase_in    = '0;
        phase_valid = 1'b0;
        data_in     = '0;
        valid_in    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_quiet("reset_state");

        // Unconfigured: samples must be ignored
        repeat (20) send(16'd1000, 16'd0, '0, 1'b0);
        idle(2);
        check_quiet("unconf_quiet");

        // DC tone
        configure(20'h0, 20'h0, 1'b0);
        repeat (8) send(16'd1000, 16'd0, DC, 1'b1);
        idle(10);

        // Quarter-turn rotation with wrap
        configure(20'h40000, 20'h0, 1'b0);
        for (int k = 0; k < 8; k++) send(16'd1000, 16'd0, quarter[k % 4], 1'b1);
        idle(10);

        // 45 degree offset with saturation both ways
        configure(20'h0, 20'h20000, 1'b0);
        repeat (3) send(16'h7FFF, 16'h7FFF, 32'h7FFF_0000, 1'b1);
        repeat (3) send(16'h8000, 16'h8000, 32'h8000_0000, 1'b1);
        idle(10);

        // Gapped input, then reconfig colliding with a sample
        configure(20'h40000, 20'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            send(16'd1000, 16'd0, quarter[k % 4], 1'b1);
            idle(1);
        end
        configure(20'h40000, 20'h40000, 1'b1);
        for (int k = 1; k < 4; k++) send(16'd1000, 16'd0, quarter[k], 1'b1);
        idle(10);

        // Reset mid-stream
        configure(20'h0, 20'h0, 1'b0);
        repeat (10) send(16'd1000, 16'd0, DC, 1'b1);
        rst = 1'b1;
        purge(edge_cnt + 1);
        send(16'd1000, 16'd0, '0, 1'b0);
        rst = 1'b0;
        check_quiet("reset_midstream");
        repeat (10) send(16'd1000, 16'd0, '0, 1'b0);
        idle(3);
        configure(20'h0, 20'h0, 1'b0);
        repeat (3) send(16'd1000, 16'd0, DC, 1'b1);
        idle(12);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs still pending, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
